msp430_mpram: RTL and testbench
===============================

MSP430_MPRAM -- requirements
Module: msp430_mpram

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of requester ports (legal 1..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width in bits (multiple of 8); BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameter ADDR_MSB, default 6, MSB of each port's word address.
REQ-004 SHALL have parameter MEM_SIZE, default 256, memory size in bytes; DEPTH = MEM_SIZE/BYTES words.
REQ-005 SHALL have ports, clock and reset first; one clock; reset is asynchronous and active-low:
- ram_clk  input  1  clock, all logic on rising edge
- ram_rst_n  input  1  asynchronous active-low reset
- ram_cen  input  PORTS  per-port request, low active
- ram_wen  input  PORTS*BYTES  per-port byte write enable, low active; all ones = read
- ram_addr  input  PORTS*(ADDR_MSB+1)  per-port word address
- ram_din  input  PORTS*DATA_WIDTH  per-port write data
- ram_rdy  output  PORTS  per-port grant, combinational, same cycle as request
- ram_dout  output  PORTS*DATA_WIDTH  per-port registered read data
- ram_dvalid  output  PORTS  one-cycle read-data strobe
- ram_err  output  PORTS  one-cycle out-of-range strobe

Function
REQ-006 SHALL hold one DEPTH x DATA_WIDTH array shared by all ports; at most one access per cycle.
REQ-007 SHALL treat port p as requesting while ram_cen[p]==0; request accepted on the rising edge where ram_cen[p]==0 and ram_rdy[p]==1.
REQ-008 SHALL assert ram_rdy for exactly one requesting port per cycle, none when no request; non-requesting ports read ram_rdy 0.
REQ-009 SHALL arbitrate round-robin: search starts at port (last_granted+1) mod PORTS; pointer updates only on a grant.
REQ-010 SHALL require a stalled requester to hold cen/wen/addr/din stable until accepted; changes while stalled are undefined.
REQ-011 SHALL, on accepted write, update each byte lane b where ram_wen[p][b]==0 with ram_din[p] lane b; other lanes unchanged; no dvalid.
REQ-012 SHALL, on accepted read, drive ram_dout[p] with mem[addr] and pulse ram_dvalid[p] the following cycle (latency 1).
REQ-013 SHALL hold ram_dout[p] at its last read value until next read on that port completes.
REQ-014 SHALL treat addr >= DEPTH as out of range: write suppressed; read returns 0; ram_err[p] pulses the cycle after acceptance (with ram_dvalid[p] for reads).
REQ-015 SHALL make a write accepted in cycle N visible to any read accepted in cycle N+1 or later.
REQ-016 SHALL serialise same-address collisions in grant order; no forwarding within one cycle needed.
REQ-017 SHALL treat a partial ram_wen (not all ones) with all lanes disabled as impossible; all-ones is always a read.
REQ-018 SHALL sustain one accepted access per cycle under continuous requests.

Reset
REQ-019 SHALL, while ram_rst_n==0: ram_dout all 0, ram_dvalid 0, ram_err 0, ram_rdy 0, RR pointer so port 0 has highest priority.
REQ-020 SHALL not reset array contents; writes pending at reset assertion are dropped.
REQ-021 SHALL resume arbitration on the first rising edge after ram_rst_n deasserts.

Structure
REQ-022 SHALL place default parameter constants, a clog2 function and a port-request struct (cen, wen, addr, din) in package msp430_mpram_pkg.
REQ-023 SHALL implement arbitration in sub-module msp430_mpram_rr_arb (PORTS request in, one-hot grant out, pointer state inside).
REQ-024 SHALL keep array, byte-lane write and output registers in msp430_mpram top.

Verification
REQ-025 Single port, PORTS=2: port0 write 0xA5C3 to addr 5 (wen 00), then read addr 5 -> ram_dvalid[0] one cycle later, ram_dout[0]=0xA5C3.
REQ-026 Byte lanes: mem[3]=0x1234, write din 0xABCD wen 01 -> read 0xAB34; then wen 10 din 0x00EF -> read 0xABEF.
REQ-027 Contention: both ports request continuously 4 cycles after reset -> grants 0,1,0,1; each stalled port's rdy low while other granted.
REQ-028 Range: DEPTH=128, port1 reads addr 127 -> valid data, err 0; addr 0x7F+1 with ADDR_MSB=7 -> dout 0, dvalid and err high one cycle; write there leaves mem unchanged.
REQ-029 Ordering: cycle N port0 write addr 9 = 0x5555, cycle N+1 port1 read addr 9 -> ram_dout[1]=0x5555.
REQ-030 Reset mid-operation: assert ram_rst_n=0 between grant and dvalid -> dvalid stays 0, dout 0; after release, port0 wins first contended grant.

Source files
------------

// File: rtl/msp430_mpram_pkg.sv
// Shared constants, helpers and types for the multi-port MSP430 RAM.
package msp430_mpram_pkg;

    localparam int unsigned DefPorts     = 2;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefAddrMsb   = 6;
    localparam int unsigned DefMemSize   = 256;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    typedef struct packed {
        logic                      cen;
        logic [DefDataWidth/8-1:0] wen;
        logic [DefAddrMsb:0]       addr;
        logic [DefDataWidth-1:0]   din;
    } port_req_t;

endpackage

// File: rtl/msp430_mpram_rr_arb.sv
// Round-robin arbiter: one-hot grant among active requests, search starts after the last winner.
module msp430_mpram_rr_arb
    import msp430_mpram_pkg::*;
#(
    parameter int unsigned PORTS = DefPorts
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PORTS-1:0] i_req,
    output logic [PORTS-1:0] o_gnt
);

    localparam int unsigned PtrW = (PORTS > 1) ? clog2(PORTS) : 1;

    logic [PtrW-1:0] r_last;
    logic [PtrW-1:0] w_last_d;
    logic            w_found;

    // Priority offset i runs from the port after the last winner round to the last winner itself.
    always_comb begin
        o_gnt    = '0;
        w_found  = 1'b0;
        w_last_d = r_last;
        for (int unsigned i = 0; i < PORTS; i++) begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                if (!w_found && i_req[j] && (j == (32'(r_last) + 1 + i) % PORTS)) begin
                    o_gnt[j] = 1'b1;
                    w_last_d = PtrW'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

    // Reset value makes port 0 the first candidate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= PtrW'(PORTS - 1);
        end else if (|o_gnt) begin
            r_last <= w_last_d;
        end
    end

endmodule

// File: rtl/msp430_mpram.sv
// Single shared RAM array serving PORTS requesters, one arbitrated access per cycle,
// byte-lane writes and registered per-port read data.
module msp430_mpram
    import msp430_mpram_pkg::*;
#(
    parameter int unsigned PORTS      = DefPorts,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_MSB   = DefAddrMsb,
    parameter int unsigned MEM_SIZE   = DefMemSize
) (
    input  logic                            ram_clk,
    input  logic                            ram_rst_n,
    input  logic [PORTS-1:0]                ram_cen,
    input  logic [PORTS*(DATA_WIDTH/8)-1:0] ram_wen,
    input  logic [PORTS*(ADDR_MSB+1)-1:0]   ram_addr,
    input  logic [PORTS*DATA_WIDTH-1:0]     ram_din,
    output logic [PORTS-1:0]                ram_rdy,
    output logic [PORTS*DATA_WIDTH-1:0]     ram_dout,
    output logic [PORTS-1:0]                ram_dvalid,
    output logic [PORTS-1:0]                ram_err
);

    localparam int unsigned Bytes = DATA_WIDTH / 8;
    localparam int unsigned Aw    = ADDR_MSB + 1;
    localparam int unsigned Depth = MEM_SIZE / Bytes;
    localparam int unsigned IdxW  = (Depth > 1) ? clog2(Depth) : 1;

    logic [PORTS-1:0]      w_req;
    logic [PORTS-1:0]      w_gnt;
    logic                  w_any;
    logic [Bytes-1:0]      w_wen;
    logic [Aw-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic                  w_read;
    logic                  w_in_range;
    logic [IdxW-1:0]       w_idx;

    logic [DATA_WIDTH-1:0]       r_mem [Depth];
    logic [PORTS*DATA_WIDTH-1:0] r_dout;
    logic [PORTS-1:0]            r_dvalid;
    logic [PORTS-1:0]            r_err;

    assign w_req = ~ram_cen;

    msp430_mpram_rr_arb #(
        .PORTS (PORTS)
    ) u_arb (
        .i_clk   (ram_clk),
        .i_rst_n (ram_rst_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // No grant is visible (or acted on) while reset is held.
    assign ram_rdy = w_gnt & {PORTS{ram_rst_n}};

    always_comb begin
        w_any  = 1'b0;
        w_wen  = '1;
        w_addr = '0;
        w_din  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (ram_rdy[p]) begin
                w_any  = 1'b1;
                w_wen  = ram_wen[p*Bytes +: Bytes];
                w_addr = ram_addr[p*Aw +: Aw];
                w_din  = ram_din[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_read     = &w_wen;
    assign w_in_range = (32'(w_addr) < Depth);
    assign w_idx      = IdxW'(w_addr);

    // Array contents survive reset on purpose.
    always_ff @(posedge ram_clk) begin
        if (w_any && !w_read && w_in_range) begin
            for (int unsigned b = 0; b < Bytes; b++) begin
                if (!w_wen[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_din[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            r_dout   <= '0;
            r_dvalid <= '0;
            r_err    <= '0;
        end else begin
            r_dvalid <= '0;
            r_err    <= '0;
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (ram_rdy[p]) begin
                    r_err[p] <= !w_in_range;
                    if (w_read) begin
                        r_dvalid[p] <= 1'b1;
                        r_dout[p*DATA_WIDTH +: DATA_WIDTH] <= w_in_range ? r_mem[w_idx] : '0;
                    end
                end
            end
        end
    end

    assign ram_dout   = r_dout;
    assign ram_dvalid = r_dvalid;
    assign ram_err    = r_err;

endmodule

// File: tb/tb_msp430_mpram.sv
// Randomised and directed bench for msp430_mpram against a word-array reference model.
module tb_msp430_mpram;

    localparam int NP    = 2;
    localparam int DEPTH = 128;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  cen   = 2'b11;
    logic [3:0]  wen   = 4'hF;
    logic [15:0] addr  = '0;
    logic [31:0] din   = '0;
    logic [1:0]  rdy;
    logic [31:0] dout;
    logic [1:0]  dvalid;
    logic [1:0]  err;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [15:0] m_mem [DEPTH];
    int          m_ptr    = NP - 1;
    logic [31:0] m_dout   = '0;
    logic [1:0]  m_dvalid = '0;
    logic [1:0]  m_err    = '0;
    logic [1:0]  m_g;
    int          m_p;
    logic [1:0]  m_w;
    logic [7:0]  m_a;
    logic [15:0] m_d;

    msp430_mpram #(
        .PORTS      (2),
        .DATA_WIDTH (16),
        .ADDR_MSB   (7),
        .MEM_SIZE   (256)
    ) dut (
        .ram_clk    (clk),
        .ram_rst_n  (rst_n),
        .ram_cen    (cen),
        .ram_wen    (wen),
        .ram_addr   (addr),
        .ram_din    (din),
        .ram_rdy    (rdy),
        .ram_dout   (dout),
        .ram_dvalid (dvalid),
        .ram_err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting port at or after the one following the last winner.
    function automatic logic [1:0] exp_grant(input logic [1:0] c, input int ptr);
        logic [1:0] r;
        r = '0;
        for (int k = 1; k <= NP; k++) begin
            if (r == '0 && !c[(ptr + k) % NP]) r[(ptr + k) % NP] = 1'b1;
        end
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ptr    = NP - 1;
                m_dout   = '0;
                m_dvalid = '0;
                m_err    = '0;
            end else begin
                m_g      = exp_grant(cen, m_ptr);
                m_dvalid = '0;
                m_err    = '0;
                if (m_g != '0) begin
                    m_p   = m_g[1] ? 1 : 0;
                    m_ptr = m_p;
                    m_w   = wen[m_p*2 +: 2];
                    m_a   = addr[m_p*8 +: 8];
                    m_d   = din[m_p*16 +: 16];
                    if (m_a >= DEPTH) m_err[m_p] = 1'b1;
                    if (m_w == 2'b11) begin
                        m_dvalid[m_p] = 1'b1;
                        m_dout[m_p*16 +: 16] = (m_a < DEPTH) ? m_mem[m_a[6:0]] : 16'h0;
                    end else if (m_a < DEPTH) begin
                        if (!m_w[0]) m_mem[m_a[6:0]][7:0]  = m_d[7:0];
                        if (!m_w[1]) m_mem[m_a[6:0]][15:8] = m_d[15:8];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("rdy", {30'd0, rdy}, {30'd0, rst_n ? exp_grant(cen, m_ptr) : 2'b00});
                check("dvalid", {30'd0, dvalid}, {30'd0, m_dvalid});
                check("err", {30'd0, err}, {30'd0, m_err});
                check("dout", dout, m_dout);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input int p, input logic [1:0] w, input logic [7:0] a,
                             input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        cen[p]          = 1'b0;
        wen[p*2 +: 2]   = w;
        addr[p*8 +: 8]  = a;
        din[p*16 +: 16] = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdy[p]) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_timeout", {31'd0, ok}, 32'd1);
        sync();
        cen[p]        = 1'b1;
        wen[p*2 +: 2] = 2'b11;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
    endtask

    logic [1:0] pat [4];
    logic [1:0] g;

    initial begin
        pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_dout", dout, 32'h0);

        for (int i = 0; i < DEPTH; i++) do_access(0, 2'b00, 8'(i), 16'($urandom));

        // Single-port write then read
        do_access(0, 2'b00, 8'd5, 16'hA5C3);
        do_access(0, 2'b11, 8'd5, 16'h0);
        @(negedge clk);
        check("rd5_dvalid", {30'd0, dvalid}, 32'd1);
        check("rd5_dout", {16'd0, dout[15:0]}, 32'hA5C3);
        sync();

        // Byte lanes
        do_access(0, 2'b00, 8'd3, 16'h1234);
        do_access(0, 2'b01, 8'd3, 16'hABCD);
        do_access(0, 2'b11, 8'd3, 16'h0);
        @(negedge clk);
        check("lane_hi", {16'd0, dout[15:0]}, 32'hAB34);
        sync();
        do_access(0, 2'b10, 8'd3, 16'h00EF);
        do_access(0, 2'b11, 8'd3, 16'h0);
        @(negedge clk);
        check("lane_lo", {16'd0, dout[15:0]}, 32'hABEF);
        sync();

        // Contention right after reset
        do_reset();
        addr = {8'd2, 8'd1};
        cen  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("contend", {30'd0, rdy}, {30'd0, pat[i]});
            sync();
        end
        cen = 2'b11;

        // Range
        do_access(1, 2'b00, 8'd127, 16'h7E7E);
        do_access(0, 2'b00, 8'd0, 16'h0101);
        do_access(1, 2'b11, 8'd127, 16'h0);
        @(negedge clk);
        check("r127_dout", {16'd0, dout[31:16]}, 32'h7E7E);
        check("r127_flags", {30'd0, err[1], dvalid[1]}, 32'b01);
        sync();
        do_access(1, 2'b11, 8'd128, 16'h0);
        @(negedge clk);
        check("r128_dout", {16'd0, dout[31:16]}, 32'h0);
        check("r128_flags", {30'd0, err[1], dvalid[1]}, 32'b11);
        sync();
        @(negedge clk);
        check("r128_pulse", {30'd0, err[1], dvalid[1]}, 32'b00);
        sync();
        do_access(1, 2'b00, 8'd128, 16'hFFFF);
        @(negedge clk);
        check("w128_flags", {30'd0, err[1], dvalid[1]}, 32'b10);
        sync();
        do_access(0, 2'b11, 8'd0, 16'h0);
        @(negedge clk);
        check("w128_nowrap", {16'd0, dout[15:0]}, 32'h0101);
        sync();

        // Write-then-read ordering across ports
        do_access(0, 2'b00, 8'd9, 16'h1111);
        do_reset();
        fork
            do_access(0, 2'b00, 8'd9, 16'h5555);
            do_access(1, 2'b11, 8'd9, 16'h0);
        join
        @(negedge clk);
        check("order_dout", {16'd0, dout[31:16]}, 32'h5555);
        sync();

        // Reset between grant and data strobe
        do_access(0, 2'b00, 8'd20, 16'h2020);
        cen[0]    = 1'b0;
        wen[1:0]  = 2'b11;
        addr[7:0] = 8'd20;
        @(negedge clk);
        check("mid_gnt", {30'd0, rdy}, 32'b01);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid_dvalid", {30'd0, dvalid}, 32'b00);
        check("mid_dout", dout, 32'h0);
        sync();
        rst_n      = 1'b1;
        cen[1]     = 1'b0;
        wen[3:2]   = 2'b11;
        addr[15:8] = 8'd21;
        @(negedge clk);
        check("post_rst_gnt", {30'd0, rdy}, 32'b01);
        sync();
        cen = 2'b11;

        // Random traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            g = rdy;
            sync();
            for (int p = 0; p < NP; p++) begin
                if (cen[p] || g[p]) begin
                    if ($urandom_range(9) < 3) begin
                        cen[p] = 1'b1;
                    end else begin
                        cen[p]          = 1'b0;
                        wen[p*2 +: 2]   = $urandom_range(1) ? 2'b11 : 2'($urandom_range(2));
                        addr[p*8 +: 8]  = 8'($urandom_range(135));
                        din[p*16 +: 16] = 16'($urandom);
                    end
                end
            end
        end
        cen = 2'b11;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
